riscv_uart_tx_bridge: RTL and testbench

//  Downstream consumer of the data-memory MMIO console port (io_valid/io_data).

---
 rtl/riscv_uart_tx_bridge.sv | 170 +++++++++++++++++
 tb/tb_riscv_uart_tx_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_uart_tx_bridge.sv
// MMIO console byte sink: buffers core writes in a FIFO and serialises them as UART frames on tx.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit (8E1); without it frames are 8N1.
module riscv_uart_tx_bridge #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          io_valid,
   input  logic [7:0]                    io_data,
   output logic                          tx,
   output logic                          busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [7:0]    head;
   logic          push;
   logic          pop;
   logic          has_data;
   logic          baud_last;

   logic [2:0]    state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
   logic          parity_bit;
`endif

   assign head      = mem[rd_ptr];
   assign has_data  = (fifo_count != '0);
   assign baud_last = (baud == BAUD_LAST);
   // The transmitter takes a byte when idle, or on the last stop-bit clock so frames abut.
   assign pop       = has_data && ((state == IDLE) || ((state == STOP) && baud_last));
   assign push      = io_valid && (!fifo_full || pop);
   assign fifo_full = (fifo_count == FULL_COUNT);
   assign busy      = (state != IDLE) || has_data;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= io_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (io_valid && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   // tx is registered: each transition loads the level of the bit being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if ((state == IDLE) || baud_last) begin
            baud <= '0;
         end else begin
            baud <= baud + 1'b1;
         end
         if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
         end
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (baud_last) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  tx      <= shift[0];
               end
            end
            DATA: begin
               if (baud_last) begin
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= parity_bit;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (baud_last) begin
                  if (pop) begin
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_uart_tx_bridge.sv
// Randomised bench for riscv_uart_tx_bridge: a queue-and-frame-timer reference model predicts
// every output each cycle. Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_riscv_uart_tx_bridge;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ioValid = 1'b0;
   logic [7:0] ioData = 8'h00;
   logic       tx;
   logic       busy;
   logic       fifoFull;
   logic [2:0] fifoCount;
   logic       overflow;

   int checks = 0;
   int passes = 0;

   logic [7:0]  modelQ[$];
   int          frameLeft = 0;
   logic [10:0] frameBits = '1;
   logic        modelOvf = 1'b0;

   riscv_uart_tx_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .io_valid(ioValid),
      .io_data(ioData),
      .tx(tx),
      .busy(busy),
      .fifo_full(fifoFull),
      .fifo_count(fifoCount),
      .overflow(overflow)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   // Single comparison point; every check is counted here
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state back to its post-reset value
   task automatic modelReset();
      modelQ.delete();
      frameLeft = 0;
      frameBits = '1;
      modelOvf  = 1'b0;
   endtask

   // One clock edge of the reference model: a frame is a fixed-length timer; the next byte is
   // taken when the line is idle or on the final clock of the running frame
   task automatic modelEdge(input logic v, input logic [7:0] d);
      bit popNow;
      bit pushNow;
      logic [7:0] b;
      if (rst) begin
         modelReset();
         return;
      end
      popNow  = (modelQ.size() > 0) && (frameLeft <= 1);
      pushNow = v && ((modelQ.size() < DEPTH) || popNow);
      if (popNow) begin
         b = modelQ.pop_front();
         frameBits = '1;
         frameBits[0] = 1'b0;
         frameBits[8:1] = b;
`ifdef UART_TX_PARITY_EN
         frameBits[9] = ^b;
`endif
         frameLeft = FRAME;
      end else if (frameLeft > 0) begin
         frameLeft--;
      end
      if (pushNow) begin
         modelQ.push_back(d);
      end
      if (v && !pushNow) begin
         modelOvf = 1'b1;
      end
   endtask

   task automatic checkAll();
      logic expTx;
      expTx = (frameLeft == 0) ? 1'b1 : frameBits[(FRAME - frameLeft) / CPB];
      checkOutput("tx",        32'(tx),        32'(expTx));
      checkOutput("fifoCount", 32'(fifoCount), 32'(modelQ.size()));
      checkOutput("fifoFull",  32'(fifoFull),  32'(modelQ.size() == DEPTH));
      checkOutput("busy",      32'(busy),      32'((frameLeft > 0) || (modelQ.size() > 0)));
      checkOutput("overflow",  32'(overflow),  32'(modelOvf));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check on the falling edge
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      ioValid = v;
      ioData  = d;
      @(posedge clk);
      modelEdge(v, d);
      @(negedge clk);
      checkAll();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 8'h00);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      modelReset();
      idleCycles(2);
      rst = 1'b0;
   endtask

   initial begin
      modelReset();
      @(negedge clk);
      checkAll();
      doReset();

      // Single 0x55 frame, then let it drain fully
      applyStimulus(1'b1, 8'h55);
      idleCycles(FRAME + 5);

      // Back-to-back bytes produce abutting frames
      applyStimulus(1'b1, 8'hA3);
      applyStimulus(1'b1, 8'h0F);
      idleCycles(2 * FRAME + 5);

      // Six consecutive strobes: one popped, four buffered, one dropped
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      end
      checkOutput("burstOverflow", 32'(overflow), 32'd1);
      checkOutput("burstFull",     32'(fifoFull), 32'd1);
      idleCycles(5 * FRAME + 5);

      // Strobe while full that lands on the stop-end pop is accepted
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      end
      for (int i = 0; i < FRAME && frameLeft != 1; i++) begin
         applyStimulus(1'b0, 8'h00);
      end
      applyStimulus(1'b1, 8'hC6);
      checkOutput("fullPopOverflow", 32'(overflow),  32'd0);
      checkOutput("fullPopCount",    32'(fifoCount), 32'd4);
      idleCycles(5 * FRAME + 5);

      // Randomised traffic with bursts that overrun the FIFO
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom_range(0, 99) < 9) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
      end
      idleCycles(6 * FRAME);

      // Asynchronous reset in the middle of data bit 3
      applyStimulus(1'b1, 8'hB4);
      for (int i = 0; i < FRAME && (FRAME - frameLeft) < 4 * CPB + 1; i++) begin
         applyStimulus(1'b0, 8'h00);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncTx",    32'(tx),        32'd1);
      checkOutput("asyncCount", 32'(fifoCount), 32'd0);
      checkOutput("asyncBusy",  32'(busy),      32'd0);
      modelReset();
      idleCycles(2);
      rst = 1'b0;
      idleCycles(20);
      applyStimulus(1'b1, 8'h3C);
      idleCycles(FRAME + 5);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
